// File: rtl/memoria_ram_sync_if.sv
// Request/response bus of the synchronous data RAM.
// The master drives requests and the slave (the RAM) drives responses.
interface memoria_ram_sync_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, init_done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, init_done
    );
endinterface

// File: rtl/memoria_ram_sync.sv
// Clocked single-port data RAM with a valid/ready request port.
// It has a registered response path of 1 or 2 cycles and a selectable
// read-during-write result. A sweep after reset clears every word.
module memoria_ram_sync #(
    parameter int            DW             = 8,
    parameter int            DEPTH          = 256,
    parameter int            AW             = $clog2(DEPTH),
    parameter int            RD_LAT         = 1,
    parameter int            RDW_MODE       = 0,
    parameter int            CLEAR_ON_RESET = 1,
    parameter logic [DW-1:0] INIT_VAL       = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    memoria_ram_sync_if.slave  bus
);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;

    logic [DW-1:0] mem_q [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    logic          accept;
    logic          in_range;

    logic          v1_q, v1_d;
    logic [DW-1:0] d1_q, d1_d;
    logic          v2_q, v2_d;
    logic [DW-1:0] d2_q, d2_d;

    // FSM next state: the clear sweep walks 0..DEPTH-1, then the RAM is ready
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (CLEAR_ON_RESET == 0) begin
                    state_d = ST_READY;
                end else if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_INIT;
        endcase
    end

    // Request decode: memory write port and the response pipeline inputs
    always_comb begin
        accept    = bus.req_valid && (state_q == ST_READY);
        in_range  = (32'(bus.req_addr) < 32'(DEPTH));
        mem_we    = 1'b0;
        mem_waddr = clr_cnt_q;
        mem_wdata = INIT_VAL;
        v1_d      = accept;
        d1_d      = d1_q;
        if ((state_q == ST_INIT) && (CLEAR_ON_RESET != 0)) begin
            mem_we = 1'b1;
        end else if (accept) begin
            if (!in_range) begin
                d1_d = INIT_VAL;
            end else begin
                // Old contents are sampled before the accepting edge updates them
                if (bus.req_we && (RDW_MODE != 0)) begin
                    d1_d = bus.req_wdata;
                end else begin
                    d1_d = mem_q[bus.req_addr];
                end
                if (bus.req_we) begin
                    mem_we    = 1'b1;
                    mem_waddr = bus.req_addr;
                    mem_wdata = bus.req_wdata;
                end
            end
        end
        v2_d = v1_q;
        d2_d = v1_q ? d1_q : d2_q;
    end

    // Storage array: no reset; only the sweep clears it
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // State, sweep counter and response pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
            v1_q      <= 1'b0;
            d1_q      <= '0;
            v2_q      <= 1'b0;
            d2_q      <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            v1_q      <= v1_d;
            d1_q      <= d1_d;
            v2_q      <= v2_d;
            d2_q      <= d2_d;
        end
    end

    // Output mapping: the second stage is used only when RD_LAT is 2
    always_comb begin
        bus.req_ready = (state_q == ST_READY);
        bus.init_done = (state_q == ST_READY);
        bus.rsp_valid = (RD_LAT == 2) ? v2_q : v1_q;
        bus.rsp_rdata = (RD_LAT == 2) ? d2_q : d1_q;
    end

endmodule

// File: tb/tb_memoria_ram_sync.sv
// Scoreboard bench for memoria_ram_sync, with three configurations side by side:
//   u0: DEPTH=16,  RD_LAT=1, RDW_MODE=0, INIT_VAL=00
//   u1: DEPTH=256, RD_LAT=1, RDW_MODE=1, INIT_VAL=00
//   u2: DEPTH=10,  RD_LAT=2, RDW_MODE=0, INIT_VAL=FF
module tb_memoria_ram_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n   [3];
    logic       b_valid [3];
    logic       b_we    [3];
    logic [7:0] b_addr  [3];
    logic [7:0] b_wdata [3];
    logic       o_ready [3];
    logic       o_valid [3];
    logic       o_done  [3];
    logic [7:0] o_rdata [3];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int lat [3]  = '{1, 1, 2};

    typedef struct {
        logic [7:0]  data;
        int unsigned due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    memoria_ram_sync_if #(.DW(8), .AW(4)) if0 ();
    memoria_ram_sync_if #(.DW(8), .AW(8)) if1 ();
    memoria_ram_sync_if #(.DW(8), .AW(4)) if2 ();

    assign if0.req_valid = b_valid[0];
    assign if0.req_we    = b_we[0];
    assign if0.req_addr  = b_addr[0][3:0];
    assign if0.req_wdata = b_wdata[0];
    assign o_ready[0]    = if0.req_ready;
    assign o_valid[0]    = if0.rsp_valid;
    assign o_done[0]     = if0.init_done;
    assign o_rdata[0]    = if0.rsp_rdata;

    assign if1.req_valid = b_valid[1];
    assign if1.req_we    = b_we[1];
    assign if1.req_addr  = b_addr[1];
    assign if1.req_wdata = b_wdata[1];
    assign o_ready[1]    = if1.req_ready;
    assign o_valid[1]    = if1.rsp_valid;
    assign o_done[1]     = if1.init_done;
    assign o_rdata[1]    = if1.rsp_rdata;

    assign if2.req_valid = b_valid[2];
    assign if2.req_we    = b_we[2];
    assign if2.req_addr  = b_addr[2][3:0];
    assign if2.req_wdata = b_wdata[2];
    assign o_ready[2]    = if2.req_ready;
    assign o_valid[2]    = if2.rsp_valid;
    assign o_done[2]     = if2.init_done;
    assign o_rdata[2]    = if2.rsp_rdata;

    memoria_ram_sync #(.DW(8), .DEPTH(16), .RD_LAT(1), .RDW_MODE(0),
                       .CLEAR_ON_RESET(1), .INIT_VAL(8'h00))
        u0 (.clk(clk), .rst_n(rst_n[0]), .bus(if0));

    memoria_ram_sync #(.DW(8), .DEPTH(256), .RD_LAT(1), .RDW_MODE(1),
                       .CLEAR_ON_RESET(1), .INIT_VAL(8'h00))
        u1 (.clk(clk), .rst_n(rst_n[1]), .bus(if1));

    memoria_ram_sync #(.DW(8), .DEPTH(10), .RD_LAT(2), .RDW_MODE(0),
                       .CLEAR_ON_RESET(1), .INIT_VAL(8'hFF))
        u2 (.clk(clk), .rst_n(rst_n[2]), .bus(if2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic bit pop_exp(input int d, output exp_t e);
        e.data = '0;
        e.due  = 0;
        case (d)
            0: if (q0.size() > 0) begin e = q0.pop_front(); return 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); return 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    // Issue one request on the next falling edge and record the expected response
    task automatic req(input int d, input bit we, input int addr,
                       input logic [7:0] wd, input logic [7:0] exp_data);
        exp_t e;
        @(negedge clk);
        b_valid[d] = 1'b1;
        b_we[d]    = we;
        b_addr[d]  = 8'(addr);
        b_wdata[d] = wd;
        e.data     = exp_data;
        e.due      = cyc + lat[d];
        push_exp(d, e);
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) begin
            @(negedge clk);
            b_valid[d] = 1'b0;
        end
    endtask

    // Release reset and count edges until init_done; optionally hammer requests meanwhile
    task automatic release_and_time(input int d, input int exp_n, input bit poke);
        int n = 0;
        @(negedge clk);
        rst_n[d] = 1'b1;
        if (poke) begin
            b_valid[d] = 1'b1;
            b_we[d]    = 1'b1;
            b_addr[d]  = 8'd5;
            b_wdata[d] = 8'h77;
        end
        while (o_done[d] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        b_valid[d] = 1'b0;
        check($sformatf("init_latency_u%0d", d), n, exp_n);
        check($sformatf("ready_after_init_u%0d", d), o_ready[d], 1);
    endtask

    task automatic check_outputs_zero(input int d, input string tag);
        check($sformatf("%s_ready_u%0d", tag, d), o_ready[d], 0);
        check($sformatf("%s_valid_u%0d", tag, d), o_valid[d], 0);
        check($sformatf("%s_rdata_u%0d", tag, d), o_rdata[d], 0);
        check($sformatf("%s_done_u%0d", tag, d), o_done[d], 0);
    endtask

    // Monitor: every response pulse is matched against the head of its queue
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (o_valid[d] === 1'b1) begin
                exp_t e;
                if (!pop_exp(d, e)) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp_u%0d actual=rsp_valid=1 data=%0h required=no response",
                             d, o_rdata[d]);
                end else begin
                    check($sformatf("rsp_data_u%0d", d), o_rdata[d], e.data);
                    check($sformatf("rsp_cycle_u%0d", d), cyc, e.due);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=still running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d]   = 1'b0;
            b_valid[d] = 1'b0;
            b_we[d]    = 1'b0;
            b_addr[d]  = '0;
            b_wdata[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) check_outputs_zero(d, "reset");

        // u0: sweep timing, cleared contents, read-first on write
        release_and_time(0, 16, 1'b0);
        for (int a = 0; a < 16; a++) req(0, 1'b0, a, 8'h00, 8'h00);
        req(0, 1'b1, 3, 8'h11, 8'h00);
        req(0, 1'b1, 3, 8'h22, 8'h11);
        req(0, 1'b0, 3, 8'h00, 8'h22);
        idle(0, 4);

        // u1: requests during the sweep are ignored; write-first on write
        release_and_time(1, 256, 1'b1);
        req(1, 1'b1, 8'h10, 8'hA5, 8'hA5);
        req(1, 1'b0, 8'h10, 8'h00, 8'hA5);
        req(1, 1'b0, 5, 8'h00, 8'h00);
        req(1, 1'b1, 3, 8'h11, 8'h11);
        req(1, 1'b1, 3, 8'h22, 8'h22);
        req(1, 1'b0, 3, 8'h00, 8'h22);
        idle(1, 4);

        // u1: asynchronous reset while outputs hold non-zero data
        @(negedge clk);
        #2 rst_n[1] = 1'b0;
        #1 check_outputs_zero(1, "async_rst");
        @(negedge clk);
        rst_n[1] = 1'b1;
        repeat (100) @(negedge clk);
        rst_n[1] = 1'b0;
        #1 check_outputs_zero(1, "midsweep_rst");
        release_and_time(1, 256, 1'b0);
        req(1, 1'b0, 200, 8'h00, 8'h00);
        req(1, 1'b0, 8'h10, 8'h00, 8'h00);
        req(1, 1'b0, 3, 8'h00, 8'h00);
        idle(1, 4);

        // u2: preload, streaming reads at RD_LAT=2, out-of-range access
        release_and_time(2, 10, 1'b0);
        for (int a = 0; a < 8; a++) req(2, 1'b1, a, 8'(8'h40 + a), 8'hFF);
        for (int a = 0; a < 8; a++) req(2, 1'b0, a, 8'h00, 8'(8'h40 + a));
        req(2, 1'b1, 12, 8'h33, 8'hFF);
        req(2, 1'b0, 12, 8'h00, 8'hFF);
        req(2, 1'b0, 9, 8'h00, 8'hFF);
        idle(2, 6);
        check("no_x_u2", 32'($isunknown({o_ready[2], o_valid[2], o_done[2], o_rdata[2]})), 0);

        check("drained_u0", q0.size(), 0);
        check("drained_u1", q1.size(), 0);
        check("drained_u2", q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
